// File: rtl/interrupt_pkg.sv
// Shared types and sizing helpers for the interrupt priority arbiter.
package interrupt_pkg;

  localparam int unsigned PRIO_W_DEF = 3;
  localparam int unsigned PRIO_MAX_W = 8;
  localparam int unsigned ID_MAX_W   = 12;

  // ID 0 is reserved for "none", so N sources need room for N+1 codes.
  function automatic int unsigned id_width(input int unsigned n_sources);
    return 32'($clog2(n_sources + 32'd1));
  endfunction

  typedef struct packed {
    logic [PRIO_MAX_W-1:0] prio;
    logic [ID_MAX_W-1:0]   id;
  } prio_id_t;

endpackage

// File: rtl/interrupt_priority_arbiter_if.sv
// Pending/enable/priority inputs, claim/complete handshake and arbiter results.
interface interrupt_priority_arbiter_if
  import interrupt_pkg::*;
#(
  parameter int unsigned N_INTERRUPTS = 32,
  parameter int unsigned PRIO_W       = PRIO_W_DEF,
  parameter int unsigned ID_W         = id_width(N_INTERRUPTS)
) ();

  logic [N_INTERRUPTS-1:0]             pending;
  logic [N_INTERRUPTS-1:0]             enable;
  logic [N_INTERRUPTS-1:0][PRIO_W-1:0] priorities;
  logic [PRIO_W-1:0]                   threshold;
  logic                                claim_req;
  logic                                complete_req;
  logic [ID_W-1:0]                     complete_id;

  logic                                irq;
  logic                                irq_rise;
  logic [ID_W-1:0]                     best_id;
  logic [N_INTERRUPTS-1:0]             best_onehot;
  logic                                claim_ack;
  logic [ID_W-1:0]                     claim_id;
  logic [N_INTERRUPTS-1:0]             in_service;

  modport master (
    output pending, enable, priorities, threshold, claim_req, complete_req, complete_id,
    input  irq, irq_rise, best_id, best_onehot, claim_ack, claim_id, in_service
  );

  modport slave (
    input  pending, enable, priorities, threshold, claim_req, complete_req, complete_id,
    output irq, irq_rise, best_id, best_onehot, claim_ack, claim_id, in_service
  );

endinterface

// File: rtl/interrupt_max_tree.sv
// Combinational max-priority tree; leaves padded to a power of two, ties resolve to the lower ID.
module interrupt_max_tree
  import interrupt_pkg::*;
#(
  parameter int unsigned N      = 32,
  parameter int unsigned PRIO_W = PRIO_W_DEF
) (
  input  logic [N-1:0]             elig_i,
  input  logic [N-1:0][PRIO_W-1:0] prio_i,
  output prio_id_t                 winner_c
);

  localparam int unsigned LEVELS = 32'($clog2(N));
  localparam int unsigned LEAVES = 32'd1 << LEVELS;
  localparam int unsigned NODES  = 2 * LEAVES - 1;
  localparam int unsigned PAD_W  = LEAVES * PRIO_W;

  logic [LEAVES-1:0]             elig_pad;
  logic [LEAVES-1:0][PRIO_W-1:0] prio_pad;
  prio_id_t                      node [NODES];

  assign elig_pad = LEAVES'(elig_i);
  assign prio_pad = PAD_W'(prio_i);

  // Heap layout: node i has children 2i+1 (lower IDs) and 2i+2; leaves start at LEAVES-1.
  always_comb begin
    for (int unsigned k = 0; k < LEAVES; k++) begin
      node[LEAVES-1+k] = '0;
      if (elig_pad[k]) begin
        node[LEAVES-1+k].prio = PRIO_MAX_W'(prio_pad[k]);
        node[LEAVES-1+k].id   = ID_MAX_W'(k + 32'd1);
      end
    end
    for (int i = int'(LEAVES) - 2; i >= 0; i--) begin
      node[i] = (node[2*i+1].prio >= node[2*i+2].prio) ? node[2*i+1] : node[2*i+2];
    end
  end

  assign winner_c = node[0];

endmodule

// File: rtl/interrupt_priority_arbiter.sv
// Interrupt arbiter: eligibility mask, in-service tracking, registered winner and claim/complete handshake.
module interrupt_priority_arbiter
  import interrupt_pkg::*;
#(
  parameter int unsigned N_INTERRUPTS = 32,
  parameter int unsigned PRIO_W       = PRIO_W_DEF,
  parameter int unsigned ID_W         = id_width(N_INTERRUPTS)
) (
  input  logic                        clk,
  input  logic                        n_rst,
  interrupt_priority_arbiter_if.slave bus
);

  logic [N_INTERRUPTS-1:0] in_service_q, in_service_d;
  logic [N_INTERRUPTS-1:0] elig;
  logic [ID_W-1:0]         best_id_q, best_id_d;
  logic [N_INTERRUPTS-1:0] best_onehot_q, best_onehot_d;
  logic                    irq_q, irq_d;
  logic                    irq_rise_q;
  logic                    claim_ack_q;
  logic [ID_W-1:0]         claim_id_q;
  logic                    complete_ok;
  prio_id_t                winner;

  assign complete_ok = bus.complete_req && (bus.complete_id != '0) &&
                       (32'(bus.complete_id) <= N_INTERRUPTS);

  // Complete clears first, claim sets; best_id_q is never in service so they cannot collide.
  always_comb begin
    in_service_d = in_service_q;
    for (int unsigned k = 0; k < N_INTERRUPTS; k++) begin
      if (complete_ok && (bus.complete_id == ID_W'(k + 32'd1))) begin
        in_service_d[k] = 1'b0;
      end
      if (bus.claim_req && (best_id_q == ID_W'(k + 32'd1))) begin
        in_service_d[k] = 1'b1;
      end
    end
  end

  always_comb begin
    elig = '0;
    for (int unsigned k = 0; k < N_INTERRUPTS; k++) begin
      elig[k] = bus.pending[k] && bus.enable[k] && !in_service_d[k] &&
                (bus.priorities[k] > bus.threshold);
    end
  end

  interrupt_max_tree #(
    .N      (N_INTERRUPTS),
    .PRIO_W (PRIO_W)
  ) u_tree (
    .elig_i   (elig),
    .prio_i   (bus.priorities),
    .winner_c (winner)
  );

  // Eligible sources always have non-zero priority, so a zero-priority root means no winner.
  always_comb begin
    best_id_d = '0;
    if ((winner.prio != '0) && (winner.id <= ID_MAX_W'(N_INTERRUPTS))) begin
      best_id_d = ID_W'(winner.id);
    end
    irq_d         = (best_id_d != '0);
    best_onehot_d = '0;
    for (int unsigned k = 0; k < N_INTERRUPTS; k++) begin
      best_onehot_d[k] = (best_id_d == ID_W'(k + 32'd1));
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      in_service_q  <= '0;
      best_id_q     <= '0;
      best_onehot_q <= '0;
      irq_q         <= 1'b0;
      irq_rise_q    <= 1'b0;
      claim_ack_q   <= 1'b0;
      claim_id_q    <= '0;
    end else begin
      in_service_q  <= in_service_d;
      best_id_q     <= best_id_d;
      best_onehot_q <= best_onehot_d;
      irq_q         <= irq_d;
      irq_rise_q    <= irq_d && !irq_q;
      claim_ack_q   <= bus.claim_req;
      claim_id_q    <= bus.claim_req ? best_id_q : '0;
    end
  end

  assign bus.irq         = irq_q;
  assign bus.irq_rise    = irq_rise_q;
  assign bus.best_id     = best_id_q;
  assign bus.best_onehot = best_onehot_q;
  assign bus.claim_ack   = claim_ack_q;
  assign bus.claim_id    = claim_id_q;
  assign bus.in_service  = in_service_q;

endmodule

// File: tb/tb_interrupt_priority_arbiter.sv
// Scoreboard bench for interrupt_priority_arbiter: a 32-source and a 5-source instance.
module tb_interrupt_priority_arbiter;

  localparam int K_BEST    = 0;
  localparam int K_IRQ     = 1;
  localparam int K_RISE    = 2;
  localparam int K_ONEHOT  = 3;
  localparam int K_ACK     = 4;
  localparam int K_CLAIMID = 5;
  localparam int K_INSVC   = 6;

  typedef struct {
    int unsigned at;
    int          dut;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        n_rst;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  exp_t        exp_q[$];
  int unsigned claim_qa[$];
  int unsigned claim_qb[$];
  string       kname [7] = '{"best_id", "irq", "irq_rise", "best_onehot",
                             "claim_ack", "claim_id", "in_service"};

  interrupt_priority_arbiter_if #(.N_INTERRUPTS(32)) ifa ();
  interrupt_priority_arbiter_if #(.N_INTERRUPTS(5))  ifb ();

  interrupt_priority_arbiter #(.N_INTERRUPTS(32)) dut_a (.clk(clk), .n_rst(n_rst), .bus(ifa));
  interrupt_priority_arbiter #(.N_INTERRUPTS(5))  dut_b (.clk(clk), .n_rst(n_rst), .bus(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input int d, input int k);
    logic [31:0] v;
    v = 'x;
    if (d == 0) begin
      case (k)
        K_BEST:    v = 32'(ifa.best_id);
        K_IRQ:     v = 32'(ifa.irq);
        K_RISE:    v = 32'(ifa.irq_rise);
        K_ONEHOT:  v = 32'(ifa.best_onehot);
        K_ACK:     v = 32'(ifa.claim_ack);
        K_CLAIMID: v = 32'(ifa.claim_id);
        default:   v = 32'(ifa.in_service);
      endcase
    end else begin
      case (k)
        K_BEST:    v = 32'(ifb.best_id);
        K_IRQ:     v = 32'(ifb.irq);
        K_RISE:    v = 32'(ifb.irq_rise);
        K_ONEHOT:  v = 32'(ifb.best_onehot);
        K_ACK:     v = 32'(ifb.claim_ack);
        K_CLAIMID: v = 32'(ifb.claim_id);
        default:   v = 32'(ifb.in_service);
      endcase
    end
    return v;
  endfunction

  // Monitor: cycle-stamped expectations plus claim_id whenever an ack is presented.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    int unsigned want;
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      e   = exp_q.pop_front();
      act = sample(e.dut, e.kind);
      n_checks++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s dut%0d cyc%0d: got 0x%0h expected 0x%0h",
                 kname[e.kind], e.dut, cyc, act, e.val);
      end
    end
    if (ifa.claim_ack === 1'b1) begin
      n_checks++;
      if (claim_qa.size() == 0) begin
        n_fail++;
        $display("FAIL claim_ack dut0 cyc%0d: got unexpected ack id %0d expected no ack", cyc, ifa.claim_id);
      end else begin
        want = claim_qa.pop_front();
        if (32'(ifa.claim_id) !== want) begin
          n_fail++;
          $display("FAIL claim_id dut0 cyc%0d: got %0d expected %0d", cyc, ifa.claim_id, want);
        end
      end
    end
    if (ifb.claim_ack === 1'b1) begin
      n_checks++;
      if (claim_qb.size() == 0) begin
        n_fail++;
        $display("FAIL claim_ack dut1 cyc%0d: got unexpected ack id %0d expected no ack", cyc, ifb.claim_id);
      end else begin
        want = claim_qb.pop_front();
        if (32'(ifb.claim_id) !== want) begin
          n_fail++;
          $display("FAIL claim_id dut1 cyc%0d: got %0d expected %0d", cyc, ifb.claim_id, want);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input int d, input int k, input logic [31:0] v);
    exp_t e;
    e.at   = cyc + 1;
    e.dut  = d;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic ex_reset(input int d);
    for (int k = 0; k < 7; k++) ex(d, k, 32'd0);
  endtask

  initial begin
    n_rst = 1'b0;
    ifa.pending = '0; ifa.enable = '0; ifa.priorities = '0; ifa.threshold = '0;
    ifa.claim_req = 1'b0; ifa.complete_req = 1'b0; ifa.complete_id = '0;
    ifb.pending = '0; ifb.enable = '0; ifb.priorities = '0; ifb.threshold = '0;
    ifb.claim_req = 1'b0; ifb.complete_req = 1'b0; ifb.complete_id = '0;

    tick();                                   // cyc 1, reset held
    ex_reset(0); ex_reset(1);
    tick();                                   // cyc 2
    n_rst = 1'b1;
    ifa.enable = '1;
    ifa.pending[4] = 1'b1; ifa.pending[9] = 1'b1;
    ifa.priorities[4] = 3'd5; ifa.priorities[9] = 3'd5;
    ex(0, K_BEST, 5); ex(0, K_IRQ, 1); ex(0, K_RISE, 1); ex(0, K_ONEHOT, 32'h10);
    tick();                                   // cyc 3
    ex(0, K_BEST, 5); ex(0, K_RISE, 0);
    tick();                                   // cyc 4: threshold filter
    ifa.pending = 32'h4; ifa.priorities[2] = 3'd2; ifa.threshold = 3'd2;
    ex(0, K_BEST, 0); ex(0, K_IRQ, 0);
    tick();                                   // cyc 5
    ifa.threshold = 3'd1;
    ex(0, K_BEST, 3); ex(0, K_RISE, 1);
    tick();                                   // cyc 6: claim setup
    ifa.pending = 32'h22; ifa.priorities[1] = 3'd7; ifa.priorities[5] = 3'd4; ifa.threshold = 3'd0;
    ex(0, K_BEST, 2);
    tick();                                   // cyc 7
    ifa.claim_req = 1'b1; claim_qa.push_back(2);
    ex(0, K_ACK, 1); ex(0, K_INSVC, 32'h2); ex(0, K_BEST, 6);
    tick();                                   // cyc 8
    ifa.claim_req = 1'b0; ifa.complete_req = 1'b1; ifa.complete_id = 6'd2;
    ex(0, K_INSVC, 0); ex(0, K_BEST, 2); ex(0, K_ACK, 0);
    tick();                                   // cyc 9: spurious claim
    ifa.complete_req = 1'b0; ifa.pending = '0;
    ex(0, K_BEST, 0);
    tick();                                   // cyc 10
    ifa.claim_req = 1'b1; claim_qa.push_back(0);
    ex(0, K_ACK, 1); ex(0, K_INSVC, 0);
    tick();                                   // cyc 11
    ifa.claim_req = 1'b0; ifa.pending = 32'h2;
    ex(0, K_BEST, 2);
    tick();                                   // cyc 12
    ifa.claim_req = 1'b1; claim_qa.push_back(2);
    ex(0, K_INSVC, 32'h2); ex(0, K_BEST, 0);
    tick();                                   // cyc 13: illegal completes
    ifa.claim_req = 1'b0; ifa.complete_req = 1'b1; ifa.complete_id = 6'd0;
    ex(0, K_INSVC, 32'h2);
    tick();                                   // cyc 14
    ifa.complete_id = 6'd40;
    ex(0, K_INSVC, 32'h2);
    tick();                                   // cyc 15: put source 6 in service
    ifa.complete_id = 6'd2; ifa.pending = 32'h22; ifa.enable[1] = 1'b0;
    ex(0, K_INSVC, 0); ex(0, K_BEST, 6); ex(0, K_RISE, 1);
    tick();                                   // cyc 16
    ifa.complete_req = 1'b0; ifa.claim_req = 1'b1; claim_qa.push_back(6);
    ex(0, K_INSVC, 32'h20); ex(0, K_BEST, 0);
    tick();                                   // cyc 17
    ifa.claim_req = 1'b0; ifa.enable[1] = 1'b1;
    ex(0, K_BEST, 2); ex(0, K_INSVC, 32'h20); ex(0, K_RISE, 1);
    tick();                                   // cyc 18: claim 2 and complete 6 together
    ifa.claim_req = 1'b1; ifa.complete_req = 1'b1; ifa.complete_id = 6'd6; claim_qa.push_back(2);
    ex(0, K_INSVC, 32'h2); ex(0, K_BEST, 6);
    tick();                                   // cyc 19: five-source instance
    ifa.claim_req = 1'b0; ifa.complete_req = 1'b0;
    ifb.enable = '1; ifb.pending = 5'h1f;
    ifb.priorities = {3'd6, 3'd3, 3'd3, 3'd3, 3'd3};
    ex(1, K_BEST, 5); ex(1, K_ONEHOT, 32'h10); ex(1, K_IRQ, 1);
    tick();                                   // cyc 20: reset during a claim
    n_rst = 1'b0; ifb.claim_req = 1'b1;
    ex_reset(0); ex_reset(1);
    tick();                                   // cyc 21
    n_rst = 1'b1; ifb.claim_req = 1'b0;
    ex(1, K_BEST, 5); ex(1, K_RISE, 1);
    ex(0, K_BEST, 2); ex(0, K_RISE, 1); ex(0, K_INSVC, 0);
    tick();                                   // cyc 22
    ifb.claim_req = 1'b1; claim_qb.push_back(5);
    ex(1, K_INSVC, 32'h10); ex(1, K_BEST, 1); ex(1, K_ONEHOT, 32'h1);
    tick();                                   // cyc 23
    ifb.claim_req = 1'b0;
    tick(); tick(); tick();

    n_checks++;
    if (exp_q.size() != 0 || claim_qa.size() != 0 || claim_qb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d/%0d outstanding expectations expected 0/0/0",
               exp_q.size(), claim_qa.size(), claim_qb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
